round_desc_sequencer: RTL and testbench

- Parametrised successor of the fixed round-descriptor table used by the game datapath.
- Holds a writable table of round descriptors: opcode, LED mask, initial servo position, sensor lower/upper limits (3x BCD), and expected serial string.
- Steps through the rounds under control of the game FSM, presenting decoded, registered fields plus per-round status.
- Sits between the configuration loader (write side) and the game controller/comparators (read side).

---
 rtl/round_desc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_round_desc_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_desc_sequencer.sv
// rtl/round_desc_sequencer.sv - writable round-descriptor table stepped through by the game FSM
module round_desc_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int LEDS_W = 4,
    parameter int EXP_W  = 28,
    parameter int DATA_W = 28 + LEDS_W + EXP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   num_rounds,
    input  logic              loop_mode,
    input  logic              start,
    input  logic              next,
    input  logic              abort,
    output logic [ADDR_W-1:0] round_idx,
    output logic [1:0]        opcode,
    output logic [LEDS_W-1:0] leds,
    output logic [1:0]        pos_inicial,
    output logic [11:0]       lim_inf,
    output logic [11:0]       lim_sup,
    output logic [EXP_W-1:0]  expected,
    output logic              round_valid,
    output logic              entry_loaded,
    output logic              last_round,
    output logic              done
);

    // Field positions inside the packed descriptor, counted from the LSB.
    localparam int SUP_LO  = EXP_W;
    localparam int INF_LO  = EXP_W + 12;
    localparam int POS_LO  = EXP_W + 24;
    localparam int LEDS_LO = EXP_W + 26;
    localparam int OP_LO   = EXP_W + 26 + LEDS_W;

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     n_reg;
    logic                loop_reg;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    loaded;

    logic [DATA_W-1:0]   rd_word;
    logic [ADDR_W:0]     n_start;
    logic [ADDR_W:0]     n_last;
    logic                at_last;

    // Round count clamps to the table size; an empty sequence goes straight to DONE.
    assign n_start = (num_rounds > DEPTH_N) ? DEPTH_N : num_rounds;
    assign n_last  = n_reg - 1'b1;
    assign at_last = ({1'b0, ptr} == n_last);

    // Entries never written since reset are masked to an all-zero descriptor.
    assign rd_word = loaded[ptr] ? mem[ptr] : '0;

    assign round_idx = ptr;

    // Descriptor storage: written by the loader, deliberately left without reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Per-entry loaded flags; reset invalidates the whole table at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loaded <= '0;
        end else if (wr_en) begin
            loaded[wr_addr] <= 1'b1;
        end
    end

    // Sequencer FSM with registered descriptor snapshot and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            n_reg        <= '0;
            loop_reg     <= 1'b0;
            opcode       <= '0;
            leds         <= '0;
            pos_inicial  <= '0;
            lim_inf      <= '0;
            lim_sup      <= '0;
            expected     <= '0;
            round_valid  <= 1'b0;
            entry_loaded <= 1'b0;
            last_round   <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            ptr         <= '0;
            round_valid <= 1'b0;
            last_round  <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ptr      <= '0;
                        n_reg    <= n_start;
                        loop_reg <= loop_mode;
                        if (n_start != '0) begin
                            state <= FETCH;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    // The array read sees pre-write data for a same-cycle write to ptr.
                    opcode       <= rd_word[OP_LO +: 2];
                    leds         <= rd_word[LEDS_LO +: LEDS_W];
                    pos_inicial  <= rd_word[POS_LO +: 2];
                    lim_inf      <= rd_word[INF_LO +: 12];
                    lim_sup      <= rd_word[SUP_LO +: 12];
                    expected     <= rd_word[EXP_W-1:0];
                    entry_loaded <= loaded[ptr];
                    round_valid  <= 1'b1;
                    last_round   <= at_last;
                    state        <= PRESENT;
                end

                PRESENT: begin
                    if (next) begin
                        round_valid <= 1'b0;
                        last_round  <= 1'b0;
                        if (!at_last) begin
                            ptr   <= ptr + 1'b1;
                            state <= FETCH;
                        end else if (loop_reg) begin
                            ptr   <= '0;
                            state <= FETCH;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_desc_sequencer.sv
// tb/tb_round_desc_sequencer.sv - directed table-driven bench for round_desc_sequencer
module tb_round_desc_sequencer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int LEDS_W = 4;
    localparam int EXP_W  = 28;
    localparam int DATA_W = 60;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   num_rounds;
    logic              loop_mode;
    logic              start;
    logic              next;
    logic              abort;
    logic [ADDR_W-1:0] round_idx;
    logic [1:0]        opcode;
    logic [LEDS_W-1:0] leds;
    logic [1:0]        pos_inicial;
    logic [11:0]       lim_inf;
    logic [11:0]       lim_sup;
    logic [EXP_W-1:0]  expected;
    logic              round_valid;
    logic              entry_loaded;
    logic              last_round;
    logic              done;

    round_desc_sequencer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .LEDS_W(LEDS_W),
        .EXP_W (EXP_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .num_rounds  (num_rounds),
        .loop_mode   (loop_mode),
        .start       (start),
        .next        (next),
        .abort       (abort),
        .round_idx   (round_idx),
        .opcode      (opcode),
        .leds        (leds),
        .pos_inicial (pos_inicial),
        .lim_inf     (lim_inf),
        .lim_sup     (lim_sup),
        .expected    (expected),
        .round_valid (round_valid),
        .entry_loaded(entry_loaded),
        .last_round  (last_round),
        .done        (done)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic              is_start;
        int                idx;
        logic [DATA_W-1:0] desc;
        logic              ld;
        logic              last;
    } step_t;

    logic [DATA_W-1:0] e0, e1, e2, e1b;
    step_t seq_a [3];
    step_t seq_b [4];

    function automatic logic [DATA_W-1:0] pk(input logic [1:0] op, input logic [3:0] l,
                                             input logic [1:0] p, input logic [11:0] li,
                                             input logic [11:0] ls, input logic [27:0] e);
        return {op, l, p, li, ls, e};
    endfunction

    function automatic step_t mk(input logic s, input int i, input logic [DATA_W-1:0] d,
                                 input logic ld, input logic last);
        step_t r;
        r.is_start = s;
        r.idx      = i;
        r.desc     = d;
        r.ld       = ld;
        r.last     = last;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] fields();
        return {opcode, leds, pos_inicial, lim_inf, lim_sup, expected};
    endfunction

    // Pulse start/next, check the one-cycle gap, then the presented round.
    task automatic do_step(input step_t s, input string tag);
        if (s.is_start) start = 1'b1; else next = 1'b1;
        tick();
        start = 1'b0; next = 1'b0;
        chk($sformatf("%s gap_valid", tag), 64'(round_valid), 64'd0);
        tick();
        chk($sformatf("%s valid", tag), 64'(round_valid), 64'd1);
        chk($sformatf("%s idx", tag), 64'(round_idx), 64'(s.idx));
        chk($sformatf("%s fields", tag), 64'(fields()), 64'(s.desc));
        chk($sformatf("%s loaded", tag), 64'(entry_loaded), 64'(s.ld));
        chk($sformatf("%s last", tag), 64'(last_round), 64'(s.last));
        chk($sformatf("%s done", tag), 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_rounds = '0; loop_mode = 1'b0; start = 1'b0; next = 1'b0; abort = 1'b0;

        e0  = pk(2'b00, 4'b0001, 2'd1, 12'h123, 12'h456, 28'b1000001_0100100_0110000_0100011);
        e1  = pk(2'b01, 4'b0010, 2'd2, 12'h010, 12'h099, {7'h42, 7'h43, 7'h44, 7'h45});
        e2  = pk(2'b11, 4'b1100, 2'd3, 12'h250, 12'h750, {7'h5a, 7'h59, 7'h58, 7'h57});
        e1b = pk(2'b10, 4'b1111, 2'd0, 12'h999, 12'h001, {7'h31, 7'h32, 7'h33, 7'h34});

        seq_a[0] = mk(1'b1, 0, e0, 1'b1, 1'b0);
        seq_a[1] = mk(1'b0, 1, e1, 1'b1, 1'b0);
        seq_a[2] = mk(1'b0, 2, e2, 1'b1, 1'b1);
        seq_b[0] = mk(1'b1, 0, e0, 1'b1, 1'b0);
        seq_b[1] = mk(1'b0, 1, e1, 1'b1, 1'b0);
        seq_b[2] = mk(1'b0, 2, e2, 1'b1, 1'b1);
        seq_b[3] = mk(1'b0, 0, e0, 1'b1, 1'b0);

        repeat (2) tick();
        chk("rst valid", 64'(round_valid), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst last", 64'(last_round), 64'd0);
        chk("rst loaded", 64'(entry_loaded), 64'd0);
        chk("rst idx", 64'(round_idx), 64'd0);
        chk("rst fields", 64'(fields()), 64'd0);
        reset = 1'b0;
        tick();

        wr(4'd0, e0);
        wr(4'd1, e1);
        wr(4'd2, e2);

        // Non-loop three-round sequence.
        num_rounds = 5'd3; loop_mode = 1'b0;
        for (int i = 0; i < 3; i++) do_step(seq_a[i], $sformatf("seqA%0d", i));
        next = 1'b1; tick(); next = 1'b0;
        chk("seqA end done", 64'(done), 64'd1);
        chk("seqA end valid", 64'(round_valid), 64'd0);
        tick();
        chk("seqA hold done", 64'(done), 64'd1);
        chk("seqA hold valid", 64'(round_valid), 64'd0);

        // Loop mode: restart from DONE, wrap after round 2.
        loop_mode = 1'b1;
        for (int i = 0; i < 4; i++) do_step(seq_b[i], $sformatf("seqB%0d", i));
        do_step(mk(1'b0, 1, e1, 1'b1, 1'b0), "seqB4");

        // Write to the presented entry leaves the snapshot alone.
        wr(4'd1, e1b);
        chk("snap fields", 64'(fields()), 64'(e1));
        chk("snap valid", 64'(round_valid), 64'd1);
        do_step(mk(1'b0, 2, e2, 1'b1, 1'b1), "seqB5");
        do_step(mk(1'b0, 0, e0, 1'b1, 1'b0), "seqB6");
        do_step(mk(1'b0, 1, e1b, 1'b1, 1'b0), "seqB7");

        // Start while presenting is ignored.
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ign valid", 64'(round_valid), 64'd1);
        chk("start_ign idx", 64'(round_idx), 64'd1);

        // Abort beats next in the same cycle.
        next = 1'b1; abort = 1'b1; tick(); next = 1'b0; abort = 1'b0;
        chk("abort valid", 64'(round_valid), 64'd0);
        chk("abort idx", 64'(round_idx), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort last", 64'(last_round), 64'd0);
        tick();
        chk("abort idle valid", 64'(round_valid), 64'd0);

        // Zero rounds: straight to done with no valid pulse.
        num_rounds = 5'd0; loop_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("n0 done", 64'(done), 64'd1);
        chk("n0 valid", 64'(round_valid), 64'd0);
        tick();
        chk("n0 valid2", 64'(round_valid), 64'd0);

        // Oversized round count clamps to the table depth.
        num_rounds = 5'd20;
        for (int i = 0; i < 16; i++) begin
            logic [DATA_W-1:0] d;
            d = (i == 0) ? e0 : (i == 1) ? e1b : (i == 2) ? e2 : '0;
            do_step(mk(i == 0, i, d, i < 3, i == 15), $sformatf("n20_%0d", i));
        end
        next = 1'b1; tick(); next = 1'b0;
        chk("n20 done", 64'(done), 64'd1);
        chk("n20 valid", 64'(round_valid), 64'd0);

        // Asynchronous reset while fetching round 1 of a loaded sequence.
        num_rounds = 5'd3; loop_mode = 1'b1;
        do_step(mk(1'b1, 0, e0, 1'b1, 1'b0), "prerst");
        next = 1'b1; tick(); next = 1'b0;
        chk("prerst idx", 64'(round_idx), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst fields", 64'(fields()), 64'd0);
        chk("arst idx", 64'(round_idx), 64'd0);
        chk("arst loaded", 64'(entry_loaded), 64'd0);
        chk("arst valid", 64'(round_valid), 64'd0);
        chk("arst last", 64'(last_round), 64'd0);
        chk("arst done", 64'(done), 64'd0);
        #3 reset = 1'b0;

        // Restart without reloading; same-cycle write during FETCH returns old data.
        start = 1'b1; tick(); start = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = e0;
        tick();
        wr_en = 1'b0;
        chk("rbw valid", 64'(round_valid), 64'd1);
        chk("rbw fields", 64'(fields()), 64'd0);
        chk("rbw loaded", 64'(entry_loaded), 64'd0);
        do_step(mk(1'b0, 1, '0, 1'b0, 1'b0), "post1");
        do_step(mk(1'b0, 2, '0, 1'b0, 1'b1), "post2");
        do_step(mk(1'b0, 0, e0, 1'b1, 1'b0), "post0");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
